// File: rtl/flt_operand_stream_tx.sv
// flt_operand_stream_tx: streams ROM test operands as AXI4-Stream beats with index in tuser
module flt_operand_stream_tx #(
  parameter int EXP_WIDTH   = 8,
  parameter int MAN_WIDTH   = 23,
  parameter int NUM_VECTORS = 10,
  localparam int W = 1 + EXP_WIDTH + MAN_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic         i_loop_en,
  output logic         o_busy,
  output logic         o_done,
  output logic [3:0]   o_rom_addr,
  input  logic [W-1:0] i_rom_dout,
  output logic [W-1:0] o_m_axis_tdata,
  output logic         o_m_axis_tvalid,
  input  logic         i_m_axis_tready,
  output logic         o_m_axis_tlast,
  output logic [3:0]   o_m_axis_tuser
);
  typedef enum logic {S_IDLE, S_RUN} state_t;
  localparam logic [3:0] LAST = 4'(NUM_VECTORS - 1);
  state_t       r_state, w_state_nxt;
  logic [W-1:0] r_data [2];
  logic [3:0]   r_idx [2];
  logic         r_rd, r_wr, r_pend, r_exh, r_done;
  logic [1:0]   r_cnt, w_cred;
  logic [3:0]   r_issue_addr, r_rom_addr;
  logic         w_valid, w_pop, w_last, w_last_hs, w_stop, w_issue, w_start;
  assign w_valid   = r_cnt != 2'd0;
  assign w_pop     = w_valid & i_m_axis_tready;
  assign w_last    = r_idx[r_rd] == LAST;
  assign w_last_hs = w_pop & w_last;
  assign w_stop    = w_last_hs & ~i_loop_en;
  assign w_start   = (r_state == S_IDLE) & i_start;
  // credits freed by this cycle's pop are reusable at once, which keeps beats back-to-back
  assign w_cred    = r_cnt + {1'b0, r_pend} - {1'b0, w_pop};
  // reads for the next pass are issued ahead of the tlast handshake while looping;
  // a stop at that handshake flushes them
  assign w_issue   = (r_state == S_RUN) & ~r_exh & ~w_stop & (w_cred < 2'd2);
  assign o_rom_addr      = w_issue ? r_issue_addr : r_rom_addr;
  assign o_busy          = r_state == S_RUN;
  assign o_done          = r_done;
  assign o_m_axis_tvalid = w_valid;
  assign o_m_axis_tdata  = w_valid ? r_data[r_rd] : '0;
  assign o_m_axis_tuser  = w_valid ? r_idx[r_rd] : 4'd0;
  assign o_m_axis_tlast  = w_valid & w_last;
  // next state: start launches a pass, a non-looping tlast handshake ends it
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = w_start ? S_RUN : (w_stop ? S_IDLE : r_state);
  end
  // state register and end-of-pass pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_stop;
    end
  end
  // fetch side: address counter, exhausted flag and the single in-flight read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issue_addr <= 4'd0;
      r_exh        <= 1'b0;
      r_pend       <= 1'b0;
      r_rom_addr   <= 4'd0;
    end else begin
      r_pend <= w_issue;
      if (w_start || (w_last_hs && r_exh)) begin
        r_issue_addr <= 4'd0;
        r_exh        <= 1'b0;
      end else if (w_issue) begin
        r_rom_addr   <= r_issue_addr;
        r_issue_addr <= (r_issue_addr == LAST) ? 4'd0 : r_issue_addr + 4'd1;
        r_exh        <= (r_issue_addr == LAST) & ~i_loop_en;
      end
    end
  end
  // two-entry output FIFO; a stop discards anything fetched for a next pass
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= 2'd0;
      r_rd   <= 1'b0;
      r_wr   <= 1'b0;
      r_data <= '{default: '0};
      r_idx  <= '{default: '0};
    end else if (w_stop) begin
      r_cnt <= 2'd0;
      r_rd  <= 1'b0;
      r_wr  <= 1'b0;
    end else begin
      if (r_pend) begin
        r_data[r_wr] <= i_rom_dout;
        r_idx[r_wr]  <= r_rom_addr;
        r_wr         <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      r_cnt <= r_cnt + {1'b0, r_pend} - {1'b0, w_pop};
    end
  end
endmodule

// File: tb/tb_flt_operand_stream_tx.sv
// tb_flt_operand_stream_tx: randomized/directed bench with a per-beat reference model
module tb_flt_operand_stream_tx;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, loop_en = 1'b0, tready = 1'b0, clr = 1'b0;
  logic tv [4], tl [4], bz [4], dn [4];
  logic [3:0] tu [4], ad [4];
  logic [31:0] d0, d2, d3, r0, r2, r3;
  logic [63:0] d1, r1;
  int n_chk = 0, n_fail = 0, cyc = 0, c0 = 0, first_v = -1, last_hs = -1;
  int nb [4], nd [4];
  logic pstall = 1'b0, plast = 1'b0;
  logic [63:0] pdata = '0;
  logic [3:0] puser = '0;

  always #5 clk = ~clk;

  flt_operand_stream_tx #(.NUM_VECTORS(10)) u_sp (.clk(clk), .rst(rst), .i_start(start), .i_loop_en(loop_en),
    .o_busy(bz[0]), .o_done(dn[0]), .o_rom_addr(ad[0]), .i_rom_dout(r0), .o_m_axis_tdata(d0),
    .o_m_axis_tvalid(tv[0]), .i_m_axis_tready(tready), .o_m_axis_tlast(tl[0]), .o_m_axis_tuser(tu[0]));
  flt_operand_stream_tx #(.EXP_WIDTH(11), .MAN_WIDTH(52), .NUM_VECTORS(10)) u_dp (.clk(clk), .rst(rst),
    .i_start(start), .i_loop_en(loop_en), .o_busy(bz[1]), .o_done(dn[1]), .o_rom_addr(ad[1]), .i_rom_dout(r1),
    .o_m_axis_tdata(d1), .o_m_axis_tvalid(tv[1]), .i_m_axis_tready(tready), .o_m_axis_tlast(tl[1]),
    .o_m_axis_tuser(tu[1]));
  flt_operand_stream_tx #(.NUM_VECTORS(1)) u_n1 (.clk(clk), .rst(rst), .i_start(start), .i_loop_en(loop_en),
    .o_busy(bz[2]), .o_done(dn[2]), .o_rom_addr(ad[2]), .i_rom_dout(r2), .o_m_axis_tdata(d2),
    .o_m_axis_tvalid(tv[2]), .i_m_axis_tready(tready), .o_m_axis_tlast(tl[2]), .o_m_axis_tuser(tu[2]));
  flt_operand_stream_tx #(.NUM_VECTORS(16)) u_n16 (.clk(clk), .rst(rst), .i_start(start), .i_loop_en(loop_en),
    .o_busy(bz[3]), .o_done(dn[3]), .o_rom_addr(ad[3]), .i_rom_dout(r3), .o_m_axis_tdata(d3),
    .o_m_axis_tvalid(tv[3]), .i_m_axis_tready(tready), .o_m_axis_tlast(tl[3]), .o_m_axis_tuser(tu[3]));

  function automatic logic [63:0] rom_val(input logic [3:0] a);
    case (a)
      4'd0:  return 64'h3b23f17600f3e301;
      4'd1:  return 64'h3ff0000040490fdb;
      4'd2:  return 64'hc00000003f800000;
      4'd3:  return 64'h0000000100000001;
      4'd4:  return 64'h80000000bf800000;
      4'd5:  return 64'h7fefffff7f7fffff;
      4'd6:  return 64'h000fffff007fffff;
      4'd7:  return 64'h7ff800007fc00000;
      4'd8:  return 64'hfff00000ff800000;
      4'd9:  return 64'h7ff000007f800000;
      4'd10: return 64'h400921fb3e800000;
      4'd11: return 64'hbfe0000042c80000;
      4'd12: return 64'h3fb999993dcccccd;
      4'd13: return 64'hc07f400044fa0000;
      4'd14: return 64'h0010000000800000;
      default: return 64'h7fe0000049742400;
    endcase
  endfunction

  // registered ROMs, one cycle read latency
  always @(posedge clk) begin
    r0 <= 32'(rom_val(ad[0]));
    r1 <= rom_val(ad[1]);
    r2 <= 32'(rom_val(ad[2]));
    r3 <= 32'(rom_val(ad[3]));
  end
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int nv(input int i);
    return i == 2 ? 1 : (i == 3 ? 16 : 10);
  endfunction
  function automatic logic [63:0] td(input int i);
    return i == 0 ? 64'(d0) : (i == 1 ? d1 : (i == 2 ? 64'(d2) : 64'(d3)));
  endfunction
  function automatic logic [63:0] exp_data(input int i, input int idx);
    logic [63:0] v;
    v = rom_val(4'(idx));
    return i == 1 ? v : {32'h0, v[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model: beat k of an instance carries vector k mod N
  always @(negedge clk) begin
    int idx;
    if (clr || rst) begin
      for (int i = 0; i < 4; i++) begin
        nb[i] <= 0;
        nd[i] <= 0;
      end
      first_v <= -1;
      last_hs <= -1;
      pstall  <= 1'b0;
    end else begin
      if (pstall) begin
        chk("hold_valid", 64'(tv[0]), 64'd1);
        chk("hold_data", td(0), pdata);
        chk("hold_user", 64'(tu[0]), 64'(puser));
        chk("hold_last", 64'(tl[0]), 64'(plast));
      end
      pstall <= tv[0] && !tready;
      pdata  <= td(0);
      puser  <= tu[0];
      plast  <= tl[0];
      if (tv[0] && first_v < 0) first_v <= cyc;
      for (int i = 0; i < 4; i++) begin
        if (dn[i]) nd[i] <= nd[i] + 1;
        if (tv[i] && tready) begin
          idx = nb[i] % nv(i);
          chk("tuser", 64'(tu[i]), 64'(idx));
          chk("tdata", td(i), exp_data(i, idx));
          chk("tlast", 64'(tl[i]), 64'(idx == nv(i) - 1));
          nb[i] <= nb[i] + 1;
          if (i == 0) last_hs <= cyc;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic clear;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask
  task automatic pulse_start;
    c0 = cyc;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask
  task automatic wait_idle(input int lim);
    int k = 0;
    while ((bz[0] | bz[1] | bz[2] | bz[3]) && k < lim) begin
      tick(1);
      k++;
    end
    chk("idle_timeout", 64'(k < lim), 64'd1);
    tick(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    tick(3);
    chk("rst_tvalid", 64'(tv[0]), 64'd0);
    chk("rst_busy", 64'(bz[0]), 64'd0);
    chk("rst_done", 64'(dn[0]), 64'd0);
    chk("rst_addr", 64'(ad[0]), 64'd0);
    chk("rst_tdata", td(0), 64'd0);
    chk("rst_tlast_n1", 64'(tl[2]), 64'd0);
    rst = 1'b0;
    tick(2);
    // T1: free-flowing single pass, second start while busy is ignored
    clear;
    tready = 1'b1;
    pulse_start;
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_idle(200);
    chk("t1_latency", 64'(first_v - c0), 64'd3);
    chk("t1_b2b", 64'(last_hs - first_v), 64'd9);
    chk("t1_beats_sp", 64'(nb[0]), 64'd10);
    chk("t1_beats_dp", 64'(nb[1]), 64'd10);
    chk("t1_beats_n1", 64'(nb[2]), 64'd1);
    chk("t1_beats_n16", 64'(nb[3]), 64'd16);
    chk("t1_done", 64'(nd[0]), 64'd1);
    chk("t1_done_n1", 64'(nd[2]), 64'd1);
    // T2: tready toggling every cycle
    clear;
    pulse_start;
    k = 0;
    while ((bz[0] | bz[3]) && k < 200) begin
      tready = ~tready;
      tick(1);
      k++;
    end
    chk("t2_timeout", 64'(k < 200), 64'd1);
    tick(2);
    chk("t2_beats_sp", 64'(nb[0]), 64'd10);
    chk("t2_beats_n16", 64'(nb[3]), 64'd16);
    chk("t2_done", 64'(nd[0]), 64'd1);
    // T3: long stall holds beat 0 with exactly two reads issued
    clear;
    tready = 1'b0;
    pulse_start;
    tick(20);
    chk("t3_tvalid", 64'(tv[0]), 64'd1);
    chk("t3_tdata", td(0), 64'h00f3e301);
    chk("t3_tuser", 64'(tu[0]), 64'd0);
    chk("t3_addr", 64'(ad[0]), 64'd1);
    chk("t3_addr_n16", 64'(ad[3]), 64'd1);
    tready = 1'b1;
    wait_idle(200);
    chk("t3_beats", 64'(nb[0]), 64'd10);
    // T4: looping, back-to-back across wraps
    clear;
    loop_en = 1'b1;
    pulse_start;
    k = 0;
    while (nb[0] < 25 && k < 100) begin
      tick(1);
      k++;
    end
    chk("t4_count", 64'(nb[0]), 64'd25);
    chk("t4_b2b", 64'(last_hs - first_v), 64'd24);
    chk("t4_busy", 64'(bz[0]), 64'd1);
    chk("t4_no_done", 64'(nd[0]), 64'd0);
    loop_en = 1'b0;
    wait_idle(200);
    chk("t4_stop_sp", 64'(nb[0]), 64'd30);
    chk("t4_stop_dp", 64'(nb[1]), 64'd30);
    chk("t4_stop_n16", 64'(nb[3]), 64'd32);
    chk("t4_done", 64'(nd[0]), 64'd1);
    // T5: asynchronous reset mid-pass while stalled, then replay
    clear;
    pulse_start;
    k = 0;
    while (nb[0] < 5 && k < 50) begin
      tick(1);
      k++;
    end
    tready = 1'b0;
    tick(3);
    #2 rst = 1'b1;
    #1;
    chk("t5_tvalid", 64'(tv[0]), 64'd0);
    chk("t5_busy", 64'(bz[0]), 64'd0);
    chk("t5_tdata", td(0), 64'd0);
    chk("t5_tuser", 64'(tu[0]), 64'd0);
    chk("t5_addr", 64'(ad[0]), 64'd0);
    chk("t5_tvalid_dp", 64'(tv[1]), 64'd0);
    tick(2);
    rst = 1'b0;
    tick(1);
    clear;
    tready = 1'b1;
    pulse_start;
    wait_idle(200);
    chk("t5_replay", 64'(nb[0]), 64'd10);
    // T7: random tready while looping, then stop
    clear;
    loop_en = 1'b1;
    pulse_start;
    for (int i = 0; i < 60; i++) begin
      tready = 1'($urandom_range(0, 1));
      tick(1);
    end
    loop_en = 1'b0;
    k = 0;
    while ((bz[0] | bz[1] | bz[2] | bz[3]) && k < 400) begin
      tready = 1'($urandom_range(0, 1));
      tick(1);
      k++;
    end
    chk("t7_timeout", 64'(k < 400), 64'd1);
    tready = 1'b1;
    tick(2);
    chk("t7_done", 64'(nd[0]), 64'd1);
    chk("t7_whole_sp", 64'(nb[0] % 10), 64'd0);
    chk("t7_whole_n16", 64'(nb[3] % 16), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
